time_entry_ctrl: RTL and testbench
==================================

# time_entry_ctrl

Time-entry controller for the set-time path: consumes the cleaned mode/increment buttons and the long-press flag produced by the hold counter, and lets the user edit an HH:MM value field by field in BCD. It sits directly downstream of the hold counter, drives that counter's clear, and hands a committed time to the clock core via a one-cycle `valid` strobe.

## Interface
- `MAX_HOUR`, 23: highest hour value; wraps to 0 after it.
- `REPEAT_DIV`, 4: number of `tick` strobes per auto-repeat increment while long-press is active (≥1).

- `clock`  in  1  single system clock, rising edge.
- `clear`  in  1  reset, asynchronous, active-high.
- `btn_mode`  in  1  debounced, synchronous mode button level.
- `btn_inc`  in  1  debounced, synchronous increment button level.
- `hold`  in  1  long-press flag from the hold counter; high once `btn_inc` has been held long enough.
- `tick`  in  1  one-cycle timebase strobe for auto-repeat.
- `hold_clr`  out  1  registered clear for the hold counter.
- `hours_bcd`  out  8  working hours, BCD `[7:4]` tens, `[3:0]` units.
- `min_bcd`  out  8  working minutes, BCD.
- `field`  out  2  `00` idle, `01` editing hours, `10` editing minutes.
- `valid`  out  1  one-cycle commit strobe; time outputs are final while high.

## Operation
- States: IDLE, SET_H, SET_M, COMMIT.
- Edge detect: registered `mode_q`/`inc_q` (reset 0); `mode_rise = btn_mode & ~mode_q`, `inc_rise = btn_inc & ~inc_q`. An input already high when `clear` deasserts counts as a rising edge.
- Transitions:
  - IDLE→SET_H on `mode_rise`.
  - SET_H→SET_M on `mode_rise`.
  - SET_M→COMMIT on `mode_rise`.
  - COMMIT→IDLE unconditionally after one cycle.
  - No other transitions.
- `field` = `01` in SET_H, `10` in SET_M, `00` otherwise. `valid` = 1 only in COMMIT.
- Increment event, only in SET_H/SET_M:
  - Occurs on `inc_rise`, or on auto-repeat.
  - Applies to the selected field only.
  - Hours: BCD +1, wraps from `MAX_HOUR` to 00.
  - Minutes: BCD +1, wraps from 59 to 00.
  - Units carry into tens (09→10, 19→20); BCD digits never hold values above 9.
- Auto-repeat:
  - `rep_cnt` (width clog2(REPEAT_DIV)+1) counts `tick` while `hold & btn_inc` and state is SET_H/SET_M.
  - On the `tick` where `rep_cnt == REPEAT_DIV-1`, one increment fires and `rep_cnt` returns to 0.
  - `rep_cnt` is forced to 0 whenever `hold & btn_inc` is low, or in IDLE/COMMIT.
- Priority in one cycle, highest first: `mode_rise` (state advances, increment dropped), then `inc_rise`, then auto-repeat. At most one increment per cycle.
- `hold_clr`:
  - Registered; next value is 1 when `btn_inc == 0` or state is IDLE/COMMIT, else 0.
  - Result: the hold counter runs only while increment is pressed inside an edit state.
- Values persist across IDLE; they are not cleared by COMMIT.

## Timing
- Reset values while `clear` is high, asynchronously: state IDLE, `hours_bcd` 8'h00, `min_bcd` 8'h00, `field` 00, `valid` 0, `hold_clr` 1, `rep_cnt` 0, `mode_q`/`inc_q` 0.
- All outputs are registered.
- An input first sampled high at clock edge k produces its state/value update visible after edge k; no extra latency.
- `hold_clr` lags `btn_inc` by one cycle.
- `valid` is high for exactly one cycle, in the cycle after the third `mode_rise` of a sequence.
- `clear` mid-edit abandons the edit: the partially edited value is lost, and no `valid` is issued.
- A `btn_mode` or `btn_inc` held high produces a single edge; a re-press requires at least one low sample in between.

## Test plan
- Reset then idle: `clear` pulse; drive `btn_inc`=1 in IDLE for 20 cycles → outputs 00:00, `field`=00, `hold_clr`=1 throughout, no increment.
- Basic entry:
  - Stimulus: mode press; 7 inc presses; mode press; 42 inc presses; mode press.
  - Response: `field` 01→10→00; `valid` high exactly one cycle with `hours_bcd`=8'h07, `min_bcd`=8'h42.
- Wrap and BCD carry:
  - From 23 in SET_H, one inc → 8'h00.
  - From 59 in SET_M, one inc → 8'h00.
  - From 09, one inc → 8'h10; nibbles never exceed 9.
- Auto-repeat:
  - Setup: SET_M at 8'h00, `btn_inc` held, `hold` raised 4 cycles later, 12 `tick` strobes with REPEAT_DIV=4.
  - Response: 8'h01 from the edge, plus 3 repeats → 8'h04; release → `hold_clr`=1 next cycle and `rep_cnt` resets.
- Simultaneous events: `mode_rise` and `inc_rise` in the same cycle in SET_H → state becomes SET_M, hours unchanged.
- Reset mid-edit: `clear` asserted asynchronously in SET_M at 12:34 → immediately IDLE, 00:00, `hold_clr`=1, and no `valid` afterwards.

Source files
------------

// File: rtl/time_entry_ctrl_if.sv
// rtl/time_entry_ctrl_if.sv - button/strobe inputs and time/field outputs of the set-time controller
interface time_entry_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       hold;
  logic       tick;
  logic       hold_clr;
  logic [7:0] hours_bcd;
  logic [7:0] min_bcd;
  logic [1:0] field;
  logic       valid;

  modport master (
    output btn_mode, btn_inc, hold, tick,
    input  hold_clr, hours_bcd, min_bcd, field, valid
  );

  modport slave (
    input  btn_mode, btn_inc, hold, tick,
    output hold_clr, hours_bcd, min_bcd, field, valid
  );
endinterface

// File: rtl/time_entry_ctrl.sv
// rtl/time_entry_ctrl.sv - field-by-field BCD HH:MM entry with auto-repeat and one-cycle commit strobe
module time_entry_ctrl #(
  parameter int MAX_HOUR   = 23,
  parameter int REPEAT_DIV = 4
) (
  input logic              clock,
  input logic              clear,
  time_entry_ctrl_if.slave bus
);

  localparam int         RW        = $clog2(REPEAT_DIV) + 1;
  localparam logic [7:0] MAX_H_BCD = {4'(MAX_HOUR / 10), 4'(MAX_HOUR % 10)};
  localparam logic [7:0] MAX_M_BCD = 8'h59;

  typedef enum logic [1:0] {IDLE, SET_H, SET_M, COMMIT} state_t;

  state_t        state;
  logic          mode_q;
  logic          inc_q;
  logic [RW-1:0] rep_cnt;

  logic mode_rise;
  logic inc_rise;
  logic editing;
  logic rep_armed;
  logic rep_top;
  logic inc_evt;

  // One-step BCD increment; the caller's wrap point is given in BCD.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == top)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_comb begin
    mode_rise = bus.btn_mode & ~mode_q;
    inc_rise  = bus.btn_inc & ~inc_q;
    editing   = (state == SET_H) || (state == SET_M);
    rep_armed = bus.hold & bus.btn_inc & editing;
    rep_top   = (rep_cnt == RW'(REPEAT_DIV - 1));
    // A mode edge wins over any increment source in the same cycle.
    inc_evt   = editing & ~mode_rise & (inc_rise | (rep_armed & bus.tick & rep_top));
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state         <= IDLE;
      mode_q        <= 1'b0;
      inc_q         <= 1'b0;
      rep_cnt       <= '0;
      bus.hours_bcd <= 8'h00;
      bus.min_bcd   <= 8'h00;
      bus.field     <= 2'b00;
      bus.valid     <= 1'b0;
      bus.hold_clr  <= 1'b1;
    end else begin
      mode_q       <= bus.btn_mode;
      inc_q        <= bus.btn_inc;
      bus.hold_clr <= ~bus.btn_inc | ~editing;

      if (!rep_armed)
        rep_cnt <= '0;
      else if (bus.tick)
        rep_cnt <= rep_top ? '0 : rep_cnt + RW'(1);

      case (state)
        IDLE: begin
          if (mode_rise) begin
            state     <= SET_H;
            bus.field <= 2'b01;
          end
        end
        SET_H: begin
          if (mode_rise) begin
            state     <= SET_M;
            bus.field <= 2'b10;
          end else if (inc_evt) begin
            bus.hours_bcd <= bcd_inc(bus.hours_bcd, MAX_H_BCD);
          end
        end
        SET_M: begin
          if (mode_rise) begin
            state     <= COMMIT;
            bus.field <= 2'b00;
            bus.valid <= 1'b1;
          end else if (inc_evt) begin
            bus.min_bcd <= bcd_inc(bus.min_bcd, MAX_M_BCD);
          end
        end
        default: begin
          state     <= IDLE;
          bus.field <= 2'b00;
          bus.valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// tb/tb_time_entry_ctrl.sv - directed self-checking bench for time_entry_ctrl
module tb_time_entry_ctrl;

  logic clock;
  logic clear;
  int   n_cmp;
  int   n_fail;
  int   exp_h;
  int   exp_m;

  time_entry_ctrl_if bus ();

  time_entry_ctrl #(.MAX_HOUR(23), .REPEAT_DIV(4)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r = {4'(v / 10), 4'(v % 10)};
    return r;
  endfunction

  task automatic press_mode();
    @(negedge clock) bus.btn_mode = 1'b1;
    @(negedge clock) bus.btn_mode = 1'b0;
  endtask

  task automatic press_inc();
    @(negedge clock) bus.btn_inc = 1'b1;
    @(negedge clock) bus.btn_inc = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.hold     = 1'b0;
    bus.tick     = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({bus.hours_bcd, bus.min_bcd, bus.field, bus.valid, bus.hold_clr} !== {8'h00, 8'h00, 2'b00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got h=%h m=%h f=%b v=%b hc=%b, want 00 00 00 0 1",
               bus.hours_bcd, bus.min_bcd, bus.field, bus.valid, bus.hold_clr);
    end
    n_cmp++;
    if (dut.rep_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_rep_cnt: got %0d want 0", dut.rep_cnt);
    end
    bus.btn_inc = 1'b1;
    @(negedge clock) clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({bus.hours_bcd, bus.min_bcd, bus.field, bus.valid, bus.hold_clr} !== {8'h00, 8'h00, 2'b00, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL idle_inc cycle %0d: got h=%h m=%h f=%b v=%b hc=%b, want 00 00 00 0 1",
                 i, bus.hours_bcd, bus.min_bcd, bus.field, bus.valid, bus.hold_clr);
      end
    end
    bus.btn_inc = 1'b0;
    @(negedge clock);
    exp_h = 0;
    exp_m = 0;
  endtask

  task automatic test_basic();
    press_mode();
    n_cmp++;
    if (bus.field !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_field_h: got %b want 01", bus.field);
    end
    repeat (7) press_inc();
    n_cmp++;
    if (bus.hours_bcd !== 8'h07) begin
      n_fail++;
      $display("FAIL basic_hours: got %h want 07", bus.hours_bcd);
    end
    press_mode();
    n_cmp++;
    if (bus.field !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_field_m: got %b want 10", bus.field);
    end
    repeat (42) press_inc();
    n_cmp++;
    if (bus.min_bcd !== 8'h42 || bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_minutes: got m=%h v=%b want 42 0", bus.min_bcd, bus.valid);
    end
    press_mode();
    n_cmp++;
    if ({bus.valid, bus.field, bus.hours_bcd, bus.min_bcd} !== {1'b1, 2'b00, 8'h07, 8'h42}) begin
      n_fail++;
      $display("FAIL basic_commit: got v=%b f=%b h=%h m=%h want 1 00 07 42",
               bus.valid, bus.field, bus.hours_bcd, bus.min_bcd);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_cmp++;
      if (bus.valid !== 1'b0 || bus.field !== 2'b00) begin
        n_fail++;
        $display("FAIL basic_valid_once cycle %0d: got v=%b f=%b want 0 00", i, bus.valid, bus.field);
      end
    end
    exp_h = 7;
    exp_m = 42;
  endtask

  task automatic test_wrap();
    press_mode();
    for (int i = 0; i < 27; i++) begin
      press_inc();
      exp_h = (exp_h + 1) % 24;
      n_cmp++;
      if (bus.hours_bcd !== to_bcd(exp_h) || bus.hours_bcd[3:0] > 4'd9 || bus.hours_bcd[7:4] > 4'd9) begin
        n_fail++;
        $display("FAIL wrap_hours step %0d: got %h want %h", i, bus.hours_bcd, to_bcd(exp_h));
      end
    end
    press_mode();
    for (int i = 0; i < 28; i++) begin
      press_inc();
      exp_m = (exp_m + 1) % 60;
      n_cmp++;
      if (bus.min_bcd !== to_bcd(exp_m) || bus.min_bcd[3:0] > 4'd9 || bus.min_bcd[7:4] > 4'd9) begin
        n_fail++;
        $display("FAIL wrap_minutes step %0d: got %h want %h", i, bus.min_bcd, to_bcd(exp_m));
      end
    end
    press_mode();
    n_cmp++;
    if ({bus.valid, bus.hours_bcd, bus.min_bcd} !== {1'b1, 8'h10, 8'h10}) begin
      n_fail++;
      $display("FAIL wrap_commit: got v=%b h=%h m=%h want 1 10 10", bus.valid, bus.hours_bcd, bus.min_bcd);
    end
  endtask

  task automatic test_autorepeat();
    press_mode();
    press_mode();
    repeat (50) press_inc();
    n_cmp++;
    if (bus.min_bcd !== 8'h00 || bus.field !== 2'b10) begin
      n_fail++;
      $display("FAIL rep_setup: got m=%h f=%b want 00 10", bus.min_bcd, bus.field);
    end
    @(negedge clock) bus.btn_inc = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (bus.min_bcd !== 8'h01 || bus.hold_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL rep_first_edge: got m=%h hc=%b want 01 0", bus.min_bcd, bus.hold_clr);
    end
    repeat (3) @(negedge clock);
    bus.hold = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock) bus.tick = 1'b1;
      @(negedge clock) bus.tick = 1'b0;
      if (i % 4 == 3) begin
        n_cmp++;
        if (bus.min_bcd !== to_bcd(2 + i / 4)) begin
          n_fail++;
          $display("FAIL rep_tick %0d: got %h want %h", i, bus.min_bcd, to_bcd(2 + i / 4));
        end
      end
    end
    @(negedge clock) begin
      bus.btn_inc = 1'b0;
      bus.hold    = 1'b0;
    end
    @(negedge clock);
    n_cmp++;
    if (bus.hold_clr !== 1'b1 || dut.rep_cnt !== '0 || bus.min_bcd !== 8'h04) begin
      n_fail++;
      $display("FAIL rep_release: got hc=%b rep=%0d m=%h want 1 0 04", bus.hold_clr, dut.rep_cnt, bus.min_bcd);
    end
  endtask

  task automatic test_simultaneous();
    press_mode();
    n_cmp++;
    if ({bus.valid, bus.hours_bcd, bus.min_bcd} !== {1'b1, 8'h10, 8'h04}) begin
      n_fail++;
      $display("FAIL sim_commit: got v=%b h=%h m=%h want 1 10 04", bus.valid, bus.hours_bcd, bus.min_bcd);
    end
    press_mode();
    @(negedge clock) begin
      bus.btn_mode = 1'b1;
      bus.btn_inc  = 1'b1;
    end
    @(negedge clock) begin
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
    end
    n_cmp++;
    if ({bus.field, bus.hours_bcd, bus.min_bcd} !== {2'b10, 8'h10, 8'h04}) begin
      n_fail++;
      $display("FAIL sim_mode_inc: got f=%b h=%h m=%h want 10 10 04", bus.field, bus.hours_bcd, bus.min_bcd);
    end
  endtask

  task automatic test_clear_mid_edit();
    press_mode();
    press_mode();
    repeat (2) press_inc();
    press_mode();
    repeat (29) press_inc();
    @(negedge clock) bus.btn_inc = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({bus.field, bus.hours_bcd, bus.min_bcd, bus.hold_clr} !== {2'b10, 8'h12, 8'h34, 1'b0}) begin
      n_fail++;
      $display("FAIL clr_setup: got f=%b h=%h m=%h hc=%b want 10 12 34 0",
               bus.field, bus.hours_bcd, bus.min_bcd, bus.hold_clr);
    end
    #2 clear = 1'b1;
    #1;
    n_cmp++;
    if ({bus.field, bus.hours_bcd, bus.min_bcd, bus.hold_clr, bus.valid} !== {2'b00, 8'h00, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL clr_async: got f=%b h=%h m=%h hc=%b v=%b want 00 00 00 1 0",
               bus.field, bus.hours_bcd, bus.min_bcd, bus.hold_clr, bus.valid);
    end
    @(negedge clock) begin
      bus.btn_inc = 1'b0;
      clear       = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({bus.valid, bus.field, bus.hours_bcd, bus.min_bcd} !== {1'b0, 2'b00, 8'h00, 8'h00}) begin
        n_fail++;
        $display("FAIL clr_after cycle %0d: got v=%b f=%b h=%h m=%h want 0 00 00 00",
                 i, bus.valid, bus.field, bus.hours_bcd, bus.min_bcd);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    exp_h  = 0;
    exp_m  = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_autorepeat();
    test_simultaneous();
    test_clear_mid_edit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
